conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the pixel word width (signed fixed point).
REQ-002 SHALL have parameter FRAC_WIDTH, default 15, the fractional bits (pass-through only, no arithmetic).
REQ-003 SHALL have parameter IMG_WIDTH, default 28, the pixels per row (minimum 3).
REQ-004 SHALL have parameter IMG_HEIGHT, default 28, the rows per frame (minimum 3).
REQ-005 SHALL have parameter KERNEL_ELEMENT_NUM, default 9, the window size (fixed 3x3).
REQ-006 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port i_reset, input, 1, the asynchronous active-high reset.
REQ-008 SHALL have port i_enable, input, 1, the stall control; low freezes all state.
REQ-009 SHALL have port i_valid, input, 1, the pixel present on i_data.
REQ-010 SHALL have port i_data, input, DATA_WIDTH, the raster-order pixel stream (row-major, top-left first).
REQ-011 SHALL have port o_data, output, DATA_WIDTH x [0:KERNEL_ELEMENT_NUM-1], the 3x3 window: [0..2] top row left-to-right, [3..5] middle row, [6..8] bottom row (newest pixel in [8]).
REQ-012 SHALL have port o_valid, output, 1, a one-cycle pulse marking o_data as a new complete window.
REQ-013 SHALL have port o_done, output, 1, a one-cycle pulse coincident with the last window of a frame.

Function
REQ-014 SHALL accept a pixel on a rising edge only when i_valid && i_enable ("accept").
REQ-015 SHALL keep col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters that advance on accept only; col wraps to 0 and increments row; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 (next frame, no idle cycle needed).
REQ-016 SHALL hold two line buffers of IMG_WIDTH entries: on accept, lb0[col] <= i_data and lb1[col] <= old lb0[col] (read-before-write, same edge).
REQ-017 SHALL, on accept, shift the window one column left and load the right column with {old lb1[col], old lb0[col], i_data} as rows {top, middle, bottom}.
REQ-018 SHALL assert o_valid in the cycle after an accept where row >= 2 and col >= 2 (latency 1 cycle); windows straddling a row boundary (col < 2) SHALL NOT be flagged.
REQ-019 SHALL emit exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) o_valid pulses per frame ("valid" convolution, no padding).
REQ-020 SHALL assert o_done together with o_valid for the accept at (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-021 SHALL deassert o_valid/o_done in any cycle following a non-accept edge; o_data SHALL hold its last value.
REQ-022 SHALL treat i_valid high with i_enable low as no accept (pixel not consumed; source must hold it).

Reset
REQ-023 SHALL, on i_reset high, asynchronously clear row, col, window registers, o_data (all zero), o_valid and o_done.
REQ-024 SHALL NOT reset line-buffer storage; stale contents SHALL never reach a flagged window because rows 0-1 are rewritten before row >= 2.
REQ-025 SHALL, after reset mid-frame, treat the next accepted pixel as (row 0, col 0).

Structure
REQ-026 SHALL take DATA_WIDTH, FRAC_WIDTH, KERNEL_SIZE (3) and KERNEL_ELEMENT_NUM (9) defaults from shared package cnn_pkg, also used by the adder tree.
REQ-027 SHALL instantiate sub-module line_buffer (depth IMG_WIDTH, width DATA_WIDTH, single read/write index) twice.
REQ-028 SHALL connect o_data directly to the adder tree's i_data array without reordering.

Verification
REQ-029 SHALL cover: 4x4 frame, pixels 1..16, no stalls -> first o_valid after pixel 11 with o_data = 1,2,3,5,6,7,9,10,11; 4 pulses total.
REQ-030 SHALL cover: same frame -> last window 6,7,8,10,11,12,14,15,16 with o_done high for exactly that cycle.
REQ-031 SHALL cover: i_enable low 3 cycles with i_valid high mid-row -> no pulses, o_data held, sequence identical to the no-stall run.
REQ-032 SHALL cover: pixels at (row 2, col 0/1) -> no o_valid; (row 2, col 2) -> o_valid.
REQ-033 SHALL cover: i_reset pulse after pixel 7, then fresh 1..16 -> outputs zero during reset, then windows as in the no-stall run.
REQ-034 SHALL cover: two back-to-back 4x4 frames (17..32 second) -> 8 pulses, second first window 17,18,19,21,22,23,25,26,27.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath defaults and window indexing helper
package cnn_pkg;

    localparam int CNN_DATA_WIDTH         = 32;
    localparam int CNN_FRAC_WIDTH         = 15;
    localparam int CNN_KERNEL_SIZE        = 3;
    localparam int CNN_KERNEL_ELEMENT_NUM = CNN_KERNEL_SIZE * CNN_KERNEL_SIZE;

    // Flat index of a window element; row 0 is the top row, col 0 the leftmost.
    function automatic int win_idx(input int row, input int col);
        return row * CNN_KERNEL_SIZE + col;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-index row store, combinational read, registered write
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    // Storage is deliberately not reset: rows 0-1 overwrite it before any flagged window.
    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to sliding 3x3 window generator
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH         = CNN_DATA_WIDTH,
    parameter int FRAC_WIDTH         = CNN_FRAC_WIDTH,
    parameter int IMG_WIDTH          = 28,
    parameter int IMG_HEIGHT         = 28,
    parameter int KERNEL_ELEMENT_NUM = CNN_KERNEL_ELEMENT_NUM
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic signed [DATA_WIDTH-1:0] o_data [0:KERNEL_ELEMENT_NUM-1],
    output logic                         o_valid,
    output logic                         o_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    if (FRAC_WIDTH >= DATA_WIDTH || KERNEL_ELEMENT_NUM != CNN_KERNEL_ELEMENT_NUM
        || IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_param_check
        $error("conv_window_gen: unsupported parameter set");
    end

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic [DATA_WIDTH-1:0] lb0_q;
    logic [DATA_WIDTH-1:0] lb1_q;

    assign accept   = i_valid && i_enable;
    assign last_col = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));

    // lb0 holds the previous row, lb1 the row before; lb1 is fed from lb0's old value.
    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_lb0 (
        .clk   (i_clk),
        .wr_en (accept),
        .idx   (col),
        .wdata (i_data),
        .rdata (lb0_q)
    );

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_lb1 (
        .clk   (i_clk),
        .wr_en (accept),
        .idx   (col),
        .wdata (lb0_q),
        .rdata (lb1_q)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            col     <= '0;
            row     <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            for (int k = 0; k < KERNEL_ELEMENT_NUM; k++) begin
                o_data[k] <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            if (accept) begin
                for (int r = 0; r < CNN_KERNEL_SIZE; r++) begin
                    for (int c = 0; c < CNN_KERNEL_SIZE - 1; c++) begin
                        o_data[win_idx(r, c)] <= o_data[win_idx(r, c + 1)];
                    end
                end
                o_data[win_idx(0, 2)] <= lb1_q;
                o_data[win_idx(1, 2)] <= lb0_q;
                o_data[win_idx(2, 2)] <= i_data;

                // Windows with col < 2 straddle a row boundary and are not flagged.
                o_valid <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
                o_done  <= last_row && last_col;

                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen on a 4x4 frame
module tb_conv_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 32;
    localparam int KN = 9;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic                 i_enable;
    logic                 i_valid;
    logic signed [DW-1:0] i_data;
    logic signed [DW-1:0] o_data [0:KN-1];
    logic                 o_valid;
    logic                 o_done;

    conv_window_gen #(
        .DATA_WIDTH         (DW),
        .FRAC_WIDTH         (15),
        .IMG_WIDTH          (W),
        .IMG_HEIGHT         (H),
        .KERNEL_ELEMENT_NUM (KN)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic              done;
        logic [KN-1:0][DW-1:0] w;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          v;
        logic          done;
    } vec_t;

    exp_t          sb[$];
    vec_t          tbl[16];
    int            checks   = 0;
    int            failures = 0;
    int            pulses   = 0;
    int            m_row    = 0;
    int            m_col    = 0;
    logic [DW-1:0] fr [0:H-1][0:W-1];
    logic          exp_now;
    logic [DW-1:0] held [0:KN-1];
    int            first_win [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int            last_win  [9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    int            f2_win    [9] = '{17, 18, 19, 21, 22, 23, 25, 26, 27};

    task automatic ck(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic ck_win(input string name, input int e [9]);
        for (int k = 0; k < KN; k++) begin
            ck($sformatf("%s[%0d]", name, k), o_data[k], e[k]);
        end
    endtask

    task automatic ck_zero(input string name);
        ck({name, "_valid"}, o_valid, 0);
        ck({name, "_done"}, o_done, 0);
        for (int k = 0; k < KN; k++) begin
            ck($sformatf("%s_data[%0d]", name, k), o_data[k], 0);
        end
    endtask

    // Reference frame model: a window is expected whenever a full 3x3 neighbourhood ends here.
    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        fr[m_row][m_col] = d;
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    e.w[r*3+c] = fr[m_row-2+r][m_col-2+c];
                end
            end
            e.done = (m_row == H-1) && (m_col == W-1);
            sb.push_back(e);
            exp_now = 1'b1;
        end
        if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic cycle(input logic v, input logic en, input logic [DW-1:0] d);
        exp_t e;
        i_valid  = v;
        i_enable = en;
        i_data   = d;
        exp_now  = 1'b0;
        if (v && en) model_accept(d);
        @(posedge i_clk);
        #1;
        ck("o_valid", o_valid, exp_now);
        if (o_valid) begin
            pulses++;
            ck("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                for (int k = 0; k < KN; k++) begin
                    ck($sformatf("sb_win[%0d]", k), o_data[k], e.w[k]);
                end
                ck("sb_done", o_done, e.done);
            end
        end else begin
            ck("o_done_idle", o_done, 0);
        end
    endtask

    initial begin
        logic [15:0] vmask;
        vmask = 16'hCC00;
        for (int i = 0; i < 16; i++) begin
            tbl[i].d    = DW'(i + 1);
            tbl[i].v    = vmask[i];
            tbl[i].done = (i == 15);
        end

        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        repeat (2) @(posedge i_clk);
        #1;
        ck_zero("reset");
        i_reset = 1'b0;

        // No-stall frame, table driven; also covers the (row 2, col 0/1/2) boundary.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, tbl[i].d);
            ck($sformatf("tbl_valid_px%0d", i + 1), o_valid, tbl[i].v);
            ck($sformatf("tbl_done_px%0d", i + 1), o_done, tbl[i].done);
            if (i == 10) ck_win("first_win", first_win);
            if (i == 15) ck_win("last_win", last_win);
        end
        ck("nostall_pulses", pulses, 4);

        // Stall mid-row with i_valid held high, plus one idle cycle.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                for (int k = 0; k < KN; k++) held[k] = o_data[k];
                for (int s = 0; s < 3; s++) begin
                    cycle(1'b1, 1'b0, DW'(i + 1));
                    for (int k = 0; k < KN; k++) begin
                        ck($sformatf("stall_hold[%0d]", k), o_data[k], held[k]);
                    end
                end
            end
            if (i == 9) cycle(1'b0, 1'b1, 32'hDEAD_BEEF);
            cycle(1'b1, 1'b1, DW'(i + 1));
            if (i == 10) ck_win("stall_first_win", first_win);
        end
        ck("stall_pulses", pulses, 4);

        // Reset after pixel 7, then a fresh frame.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, DW'(i + 1));
        i_valid = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        ck_zero("async_reset");
        @(posedge i_clk);
        #1;
        ck_zero("held_reset");
        i_reset = 1'b0;
        m_row = 0;
        m_col = 0;
        sb.delete();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, DW'(i + 1));
            if (i == 10) ck_win("rst_first_win", first_win);
            if (i == 15) ck_win("rst_last_win", last_win);
        end
        ck("rst_pulses", pulses, 4);

        // Two back-to-back frames.
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b1, DW'(i + 1));
            if (i == 26) ck_win("f2_first_win", f2_win);
        end
        ck("b2b_pulses", pulses, 8);
        ck("sb_drained", sb.size(), 0);

        i_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
